sr_drive_ctrl: RTL and testbench
================================

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable synchronized samples needed to accept a new request level (range 1..255).
REQ-002 Parameter PULSE_CYCLES, default 2: width in clk cycles of each S or R pulse (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 set_req  input  1  raw, asynchronous, bouncy set request level.
REQ-006 clr_req  input  1  raw, asynchronous, bouncy clear request level.
REQ-007 Q  input  1  feedback from the downstream clocked SR flip-flop output.
REQ-008 S  output  1  set drive to the SR flip-flop, registered.
REQ-009 R  output  1  reset drive to the SR flip-flop, registered.
REQ-010 busy  output  1  high while the FSM is in PULSE or CHECK.
REQ-011 conflict  output  1  one-cycle pulse on a simultaneous set/clear request.
REQ-012 fault  output  1  sticky flag for a Q mismatch, cleared only by rst.

Function
REQ-013 set_req and clr_req SHALL each pass through a 2-flop synchronizer, then a debounce counter that updates the debounced level only after the synced value differs from it for DB_CYCLES consecutive cycles.
REQ-014 A request event SHALL be a 0->1 transition of a debounced level; 1->0 transitions produce no action.
REQ-015 The FSM SHALL have states IDLE, PULSE and CHECK; busy = (state != IDLE).
REQ-016 IDLE -> PULSE on a single request event or a valid pending entry; the command (SET or CLR) is latched on entry.
REQ-017 In PULSE, S=1 for SET or R=1 for CLR for exactly PULSE_CYCLES consecutive cycles, then the FSM enters CHECK.
REQ-018 S and R SHALL never be high in the same cycle, under any input sequence.
REQ-019 CHECK lasts one cycle: Q is compared with the expected value (1 for SET, 0 for CLR); a mismatch sets fault; the next state is IDLE.
REQ-020 With a raw input held stable, S or R SHALL first be high in the cycle that begins DB_CYCLES+3 rising edges after the edge that first samples the raw input high.
REQ-021 Set and clear events in the same cycle SHALL execute neither command, pulse conflict for 1 cycle, and leave the pending entry unchanged.
REQ-022 A single event arriving while busy SHALL be stored in a one-deep pending register; a newer event overwrites an older one (latest wins).
REQ-023 A valid pending entry SHALL be consumed on the cycle after CHECK: IDLE lasts exactly 1 cycle, then PULSE.
REQ-024 A request event arriving in that same IDLE cycle SHALL take priority over the pending entry, and the pending entry is discarded.
REQ-025 An event arriving in the CHECK cycle SHALL be treated as occurring while busy.

Reset
REQ-026 On a sampled rst, the FSM goes to IDLE and the following are cleared: S=0, R=0, busy=0, conflict=0, fault=0, pending invalid, synchronizer flops 0, debounced levels 0, counters 0.
REQ-027 rst asserted during PULSE SHALL drop S/R low in the cycle after the sampling edge; the aborted command is not retried.
REQ-028 After rst deasserts, raw inputs already high SHALL generate request events through the normal synchronize and debounce path.

Verification
REQ-029 DB_CYCLES=4, PULSE_CYCLES=2, set_req held high from edge 0 -> S high for cycles 7 and 8, CHECK at cycle 9 with Q=1 -> fault stays 0.
REQ-030 set_req toggled every cycle for 10 cycles, then held low -> S and R stay 0 throughout; busy stays 0.
REQ-031 set_req and clr_req rise together and are held -> conflict high for exactly 1 cycle; S=R=0; busy=0.
REQ-032 clr_req event during a SET PULSE -> SET completes, then CLR PULSE begins exactly 2 cycles after the SET CHECK; R high for 2 cycles.
REQ-033 Q forced to 0 during a SET operation -> fault rises at the cycle after CHECK and remains 1 until rst.
REQ-034 rst asserted in the first PULSE cycle -> S=0 in the next cycle, and all outputs at reset values.

Source files
------------

// File: rtl/sr_drive_ctrl.sv
// Debounced set/clear request front end driving a clocked SR flip-flop.
// Pulses S or R for a fixed width, then checks the Q feedback.
module sr_drive_ctrl #(
    parameter int DB_CYCLES    = 4,
    parameter int PULSE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic Q,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic fault
);

    typedef enum logic [1:0] {IDLE, PULSE, CHECK} state_t;

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
    localparam logic [3:0] P_LAST  = 4'(PULSE_CYCLES - 1);

    // Channel 0 is set, channel 1 is clear.
    logic [1:0] s1, s2, db, dbp, ev;
    logic [7:0] cnt [2];

    state_t     state, state_n;
    logic       cmd, cmd_n;
    logic [3:0] pcnt, pcnt_n;
    logic       pend_vld, pend_vld_n;
    logic       pend_cmd, pend_cmd_n;
    logic       fault_n;
    logic       set_ev, clr_ev, both, single;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= '0;
            s2  <= '0;
            db  <= '0;
            dbp <= '0;
            ev  <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1  <= {clr_req, set_req};
            s2  <= s1;
            dbp <= db;
            // Rising edges only; falling debounced levels are ignored.
            ev  <= db & ~dbp;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] != db[i]) begin
                    if (cnt[i] == DB_LAST) begin
                        db[i]  <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign set_ev = ev[0];
    assign clr_ev = ev[1];
    assign both   = set_ev & clr_ev;
    assign single = set_ev ^ clr_ev;
    assign busy   = (state != IDLE);

    always_comb begin
        state_n    = state;
        cmd_n      = cmd;
        pcnt_n     = pcnt;
        pend_vld_n = pend_vld;
        pend_cmd_n = pend_cmd;
        fault_n    = fault;
        case (state)
            IDLE: begin
                if (single) begin
                    state_n    = PULSE;
                    cmd_n      = set_ev;
                    pcnt_n     = '0;
                    pend_vld_n = 1'b0;
                end else if (!both && pend_vld) begin
                    state_n    = PULSE;
                    cmd_n      = pend_cmd;
                    pcnt_n     = '0;
                    pend_vld_n = 1'b0;
                end
            end
            PULSE: begin
                if (pcnt == P_LAST) state_n = CHECK;
                else                pcnt_n  = pcnt + 4'd1;
            end
            CHECK: begin
                if (Q != cmd) fault_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE && single) begin
            pend_vld_n = 1'b1;
            pend_cmd_n = set_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cmd      <= 1'b0;
            pcnt     <= '0;
            pend_vld <= 1'b0;
            pend_cmd <= 1'b0;
            fault    <= 1'b0;
            conflict <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
        end else begin
            state    <= state_n;
            cmd      <= cmd_n;
            pcnt     <= pcnt_n;
            pend_vld <= pend_vld_n;
            pend_cmd <= pend_cmd_n;
            fault    <= fault_n;
            conflict <= both;
            // Drives follow the next state so they line up with PULSE.
            S        <= (state_n == PULSE) &&  cmd_n;
            R        <= (state_n == PULSE) && !cmd_n;
        end
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl with DB_CYCLES=4, PULSE_CYCLES=2.
// A behavioural SR flip-flop closes the Q feedback loop.
module tb_sr_drive_ctrl;

    logic clk = 1'b0;
    logic rst, set_req, clr_req, Q;
    logic S, R, busy, conflict, fault;
    logic qstuck;
    int   checks = 0;
    int   errors = 0;
    int   ccount;

    sr_drive_ctrl #(.DB_CYCLES(4), .PULSE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .Q(Q), .S(S), .R(R), .busy(busy), .conflict(conflict),
        .fault(fault)
    );

    always #5 clk = ~clk;

    initial Q = 1'b0;
    always @(posedge clk) begin
        if (qstuck)  Q <= 1'b0;
        else if (S)  Q <= 1'b1;
        else if (R)  Q <= 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc,
                       input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d: observed %b expected %b",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int cyc);
        chk({tag, "_S"}, cyc, S, 1'b0);
        chk({tag, "_R"}, cyc, R, 1'b0);
        chk({tag, "_busy"}, cyc, busy, 1'b0);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_idle("settle", i);
        end
    endtask

    initial begin
        rst = 1'b1; set_req = 1'b0; clr_req = 1'b0; qstuck = 1'b0;
        repeat (3) tick();
        chk("rst_S", 0, S, 1'b0);
        chk("rst_R", 0, R, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_conflict", 0, conflict, 1'b0);
        chk("rst_fault", 0, fault, 1'b0);

        // Set held high: S in cycles 7-8, CHECK in 9.
        rst = 1'b0; set_req = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            tick();
            chk("set_S", c, S, (c == 7 || c == 8));
            chk("set_R", c, R, 1'b0);
            chk("set_busy", c, busy, (c >= 7 && c <= 9));
        end
        chk("set_fault", 12, fault, 1'b0);
        set_req = 1'b0;
        settle(12);

        // Bouncing set request never debounces.
        for (int c = 0; c < 20; c++) begin
            set_req = (c < 10) ? ~set_req : 1'b0;
            tick();
            chk_idle("bounce", c);
        end
        settle(10);

        // Simultaneous set and clear.
        set_req = 1'b1; clr_req = 1'b1; ccount = 0;
        for (int c = 0; c <= 14; c++) begin
            tick();
            if (conflict) ccount++;
            chk_idle("conf", c);
        end
        checks++;
        assert (ccount == 1) else begin
            errors++;
            $error("FAIL conf_count: observed %0d expected 1", ccount);
        end
        set_req = 1'b0; clr_req = 1'b0;
        settle(12);

        // Clear arrives during the set pulse and runs after it.
        set_req = 1'b1;
        tick();
        chk("pend_S", 0, S, 1'b0);
        clr_req = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk("pend_S", c, S, (c == 7 || c == 8));
            chk("pend_R", c, R, (c == 11 || c == 12));
            chk("pend_busy", c, busy,
                (c >= 7 && c <= 9) || (c >= 11 && c <= 13));
        end
        chk("pend_fault", 15, fault, 1'b0);
        set_req = 1'b0; clr_req = 1'b0;
        settle(12);

        // Q stuck low during a set: fault is sticky until reset.
        qstuck = 1'b1; set_req = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            tick();
            chk("fault_S", c, S, (c == 7 || c == 8));
            chk("fault_fault", c, fault, (c >= 10));
        end
        set_req = 1'b0;
        repeat (12) tick();
        chk("fault_sticky", 24, fault, 1'b1);
        qstuck = 1'b0; rst = 1'b1;
        tick();
        chk("fault_rst", 25, fault, 1'b0);
        rst = 1'b0;
        settle(4);

        // Reset in the first pulse cycle, then the held input retriggers.
        set_req = 1'b1;
        for (int c = 0; c <= 7; c++) tick();
        chk("abort_S_pre", 7, S, 1'b1);
        rst = 1'b1;
        tick();
        chk("abort_S", 8, S, 1'b0);
        chk("abort_R", 8, R, 1'b0);
        chk("abort_busy", 8, busy, 1'b0);
        chk("abort_conflict", 8, conflict, 1'b0);
        chk("abort_fault", 8, fault, 1'b0);
        rst = 1'b0;
        for (int c = 9; c <= 20; c++) begin
            tick();
            chk("retry_S", c, S, (c == 16 || c == 17));
            chk("retry_busy", c, busy, (c >= 16 && c <= 18));
        end
        chk("retry_fault", 20, fault, 1'b0);
        set_req = 1'b0;
        settle(10);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
